mem_port_arbiter: RTL and testbench

- Shares one unified memory port between the instruction-fetch path and the load/store data path of the RISC-V core.
- Accepts one request at a time and forwards it with a req/gnt handshake.
- Routes the response back to the requester that issued it.
- Data requests have priority; a streak counter stops fetch from starving.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/arb_pick.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the memory port arbiter.
//   arb_state_t : arbiter FSM state (IDLE, REQ, WAIT)
//   owner_t     : which requester owns the in-flight transaction
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_t;

endpackage

// File: rtl/arb_pick.sv
// Fetch/data request picker with anti-starvation streak counter.
// Ports:
//   clk, reset      : clock, async active-low reset
//   if_req, d_req   : pending requests from fetch and data paths
//   enable          : arbiter is idle and may grant this cycle
//   if_gnt, d_gnt   : one-hot combinational grants
module arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  input  logic enable,
  output logic if_gnt,
  output logic d_gnt
);

  logic [3:0] streak;
  logic       starved;

  assign starved = (streak == 4'(STARVE_MAX));

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (enable) begin
      // data wins unless fetch has already been passed over STARVE_MAX times
      if (d_req && !(if_req && starved)) d_gnt = 1'b1;
      else if (if_req)                  if_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (d_gnt) begin
      if (!if_req)       streak <= '0;
      else if (!starved) streak <= streak + 4'd1;
    end else if (if_gnt) begin
      streak <= '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// One transaction outstanding at a time: grant -> REQ (mem_req until
// mem_gnt) -> WAIT (until mem_rvalid) -> response pulse to the owner.
// Ports:
//   clk, reset                    : clock, async active-low reset
//   if_req/if_addr/if_gnt         : fetch request side
//   if_rvalid/if_rdata            : fetch response
//   d_req/d_we/d_be/d_addr/d_wdata/d_gnt : data request side
//   d_rvalid/d_rdata              : load data or store acknowledge
//   mem_*                         : unified memory port
//   busy                          : a transaction is in flight
import riscv_pkg::*;

module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  arb_state_t state, state_nxt;
  owner_t     owner;
  logic       resp_take;

  arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .d_req  (d_req),
    .enable (state == IDLE),
    .if_gnt (if_gnt),
    .d_gnt  (d_gnt)
  );

  // mem_rvalid only counts while waiting; strays in IDLE/REQ are dropped
  assign resp_take = (state == WAIT) && mem_rvalid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_gnt || d_gnt) state_nxt = REQ;
      REQ:     if (mem_gnt)         state_nxt = WAIT;
      WAIT:    if (mem_rvalid)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= FETCH;
      mem_req   <= 1'b0;
      busy      <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
    end else begin
      state   <= state_nxt;
      // registered so mem_req/busy are glitch-free flops, in step with state
      mem_req <= (state_nxt == REQ);
      busy    <= (state_nxt != IDLE);

      if (d_gnt) begin
        owner     <= DATA;
        mem_we    <= d_we;
        mem_be    <= d_be;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (if_gnt) begin
        owner     <= FETCH;
        mem_we    <= 1'b0;
        mem_be    <= '1;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
      end

      if_rvalid <= resp_take && (owner == FETCH);
      d_rvalid  <= resp_take && (owner == DATA);
      if (resp_take && (owner == FETCH)) if_rdata <= mem_rdata;
      if (resp_take && (owner == DATA))  d_rdata  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, BW = DW / 8, SMAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_req, mem_we, mem_gnt, mem_rvalid, busy;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference model
  bit            txn_open, gnt_done, resp_due;
  bit            m_owner_d;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [BW-1:0] m_be;
  logic [DW-1:0] m_wdata, m_resp;
  logic [DW-1:0] exp_if_rdata, exp_d_rdata;
  int            streak;
  bit            if_pend, d_pend;
  bit            dut_grants[$];
  bit            gnt_on_rvalid;

  task automatic model_clear();
    txn_open = 0; gnt_done = 0; resp_due = 0; streak = 0;
    if_pend = 0; d_pend = 0;
  endtask

  // mode 0: no new requests, 1: random requests, 2: both requesters always asking
  task automatic run_cycle(input int mode);
    bit e_ifv, e_dv, e_ig, e_dg, want_if, want_d, fetch_due;
    e_ifv = 0; e_dv = 0;
    tick();
    if (resp_due) begin
      if (m_owner_d) begin e_dv = 1; exp_d_rdata = m_resp; end
      else begin e_ifv = 1; exp_if_rdata = m_resp; end
      txn_open = 0; gnt_done = 0; resp_due = 0;
    end
    chk("if_rvalid", if_rvalid, e_ifv);
    chk("d_rvalid", d_rvalid, e_dv);
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("d_rdata", d_rdata, exp_d_rdata);
    chk("busy", busy, txn_open);
    chk("mem_req", mem_req, txn_open && !gnt_done);
    if (txn_open && !gnt_done) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      chk("mem_be", mem_be, m_be);
      chk("mem_wdata", mem_wdata, m_wdata);
    end

    want_if = (mode == 2) || (mode == 1 && $urandom_range(0, 2) == 0);
    want_d  = (mode == 2) || (mode == 1 && $urandom_range(0, 2) == 0);
    if (!if_pend && want_if) begin if_pend = 1; if_addr = $urandom; end
    if (!d_pend && want_d) begin
      d_pend = 1; d_we = 1'($urandom); d_be = BW'($urandom);
      d_addr = $urandom; d_wdata = $urandom;
    end
    if (!if_pend) if_addr = $urandom;
    if (!d_pend) begin d_addr = $urandom; d_wdata = $urandom; d_be = BW'($urandom); end
    if_req = if_pend; d_req = d_pend;

    mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
    if (txn_open && !gnt_done) begin
      if ($urandom_range(0, 1) == 1) begin mem_gnt = 1; gnt_done = 1; end
      else if ($urandom_range(0, 3) == 0) mem_rvalid = 1;
    end else if (gnt_done) begin
      if ($urandom_range(0, 1) == 1) begin mem_rvalid = 1; m_resp = mem_rdata; resp_due = 1; end
    end else if ($urandom_range(0, 4) == 0) begin
      mem_rvalid = 1;
    end

    e_ig = 0; e_dg = 0;
    if (!txn_open) begin
      fetch_due = if_pend && (!d_pend || streak >= SMAX);
      e_ig = fetch_due;
      e_dg = d_pend && !fetch_due;
    end
    if (e_dg) begin
      streak = if_pend ? ((streak + 1 > SMAX) ? SMAX : streak + 1) : 0;
      m_owner_d = 1; m_addr = d_addr; m_we = d_we; m_be = d_be; m_wdata = d_wdata;
      d_pend = 0; txn_open = 1;
    end else if (e_ig) begin
      streak = 0;
      m_owner_d = 0; m_addr = if_addr; m_we = 0; m_be = '1; m_wdata = '0;
      if_pend = 0; txn_open = 1;
    end
    #1;
    chk("if_gnt", if_gnt, e_ig);
    chk("d_gnt", d_gnt, e_dg);
    if (if_gnt || d_gnt) dut_grants.push_back(d_gnt);
    if (d_rvalid && if_gnt) gnt_on_rvalid = 1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((txn_open || if_pend || d_pend || resp_due) && n < 300) begin
      run_cycle(0);
      n++;
    end
    chk("drain_timeout", n >= 300, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit pat[10];
    reset = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0;
    d_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    model_clear();
    exp_if_rdata = 0; exp_d_rdata = 0;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_rvalid", {if_rvalid, d_rvalid}, 0);
    tick(); reset = 1;

    // lone fetch
    tick(); if_req = 1; if_addr = 32'h40; #1;
    chk("f_if_gnt", if_gnt, 1); chk("f_d_gnt", d_gnt, 0); chk("f_mem_req0", mem_req, 0);
    tick(); if_req = 0; if_addr = 0; mem_gnt = 1; #1;
    chk("f_mem_req1", mem_req, 1); chk("f_addr", mem_addr, 32'h40);
    chk("f_we", mem_we, 0); chk("f_be", mem_be, 4'hf); chk("f_wdata", mem_wdata, 0);
    chk("f_busy", busy, 1);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0051_3093; #1;
    chk("f_mem_req2", mem_req, 0); chk("f_rvalid2", if_rvalid, 0);
    tick(); mem_rvalid = 0; mem_rdata = 32'h1111_1111; #1;
    chk("f_rvalid3", if_rvalid, 1); chk("f_rdata3", if_rdata, 32'h0051_3093);
    chk("f_d_rvalid3", d_rvalid, 0); chk("f_busy3", busy, 0);
    tick(); #1;
    chk("f_rvalid4", if_rvalid, 0); chk("f_rdata_hold", if_rdata, 32'h0051_3093);

    // stray rvalid in IDLE, then store with delayed mem_gnt and stray rvalid in REQ
    tick(); mem_rvalid = 1; mem_rdata = 32'hBAD0_0001; #1;
    chk("s_idle_busy", busy, 0);
    tick(); mem_rvalid = 0;
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; #1;
    chk("s_stray_idle", {if_rvalid, d_rvalid}, 0); chk("s_d_gnt", d_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); d_req = 0; d_we = 0; d_be = 4'hc; d_addr = $urandom; d_wdata = $urandom;
      mem_gnt = 0; mem_rvalid = (i == 1); #1;
      chk("s_mem_req", mem_req, 1); chk("s_we", mem_we, 1); chk("s_be", mem_be, 4'b0011);
      chk("s_addr", mem_addr, 32'h100); chk("s_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("s_stray_req", d_rvalid, 0);
    end
    tick(); mem_gnt = 1; mem_rvalid = 0; #1;
    chk("s_mem_req4", mem_req, 1); chk("s_addr4", mem_addr, 32'h100);
    tick(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h5; #1;
    chk("s_mem_req5", mem_req, 0); chk("s_rvalid5", d_rvalid, 0);
    tick(); mem_rvalid = 0; #1;
    chk("s_ack", d_rvalid, 1); chk("s_rdata", d_rdata, 32'h5);
    chk("s_if_rv", if_rvalid, 0); chk("s_if_rdata", if_rdata, 32'h0051_3093);
    exp_if_rdata = 32'h0051_3093; exp_d_rdata = 32'h5;

    // both high, data drops after its grant: D then F on the d_rvalid cycle
    dut_grants.delete(); gnt_on_rvalid = 0;
    if_pend = 1; d_pend = 1; if_addr = $urandom; d_we = 0; d_addr = $urandom; d_be = 4'hf;
    d_wdata = $urandom;
    drain();
    chk("both_n", dut_grants.size(), 2);
    if (dut_grants.size() == 2) begin
      chk("both_first_d", dut_grants[0], 1);
      chk("both_then_f", dut_grants[1], 0);
    end
    chk("f_gnt_on_d_rvalid", gnt_on_rvalid, 1);

    // both held continuously: D,D,D,D,F repeating
    dut_grants.delete();
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    for (int n = 0; n < 400 && dut_grants.size() < 10; n++) run_cycle(2);
    chk("starve_cnt", dut_grants.size() >= 10, 1);
    for (int i = 0; i < 10 && i < dut_grants.size(); i++) chk($sformatf("starve_%0d", i), dut_grants[i], pat[i]);
    drain();

    // reset during WAIT, late rvalid after release
    tick(); if_req = 1; if_addr = 32'h80; d_req = 0; mem_gnt = 0; mem_rvalid = 0; #1;
    chk("r_gnt", if_gnt, 1);
    tick(); if_req = 0; mem_gnt = 1; #1;
    chk("r_mem_req", mem_req, 1);
    tick(); mem_gnt = 0; #1;
    chk("r_wait_busy", busy, 1);
    #2 reset = 0; #1;
    chk("r_busy", busy, 0); chk("r_mem_addr", mem_addr, 0); chk("r_mem_be", mem_be, 0);
    chk("r_rdata", {if_rdata, d_rdata}, 0);
    tick(); reset = 1;
    tick(); tick(); mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D; #1;
    tick(); mem_rvalid = 0; #1;
    chk("r_late_rv", {if_rvalid, d_rvalid}, 0); chk("r_late_busy", busy, 0);
    chk("r_late_rdata", if_rdata, 0);
    model_clear(); exp_if_rdata = 0; exp_d_rdata = 0;

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) run_cycle(1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
